// File: rtl/tiny8_types_pkg.sv
// Shared types and defaults for the tiny8 core and its memory responder.
package tiny8_types;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } tiny8_mem_state;

    typedef logic [7:0] tiny8_word;

    localparam int TINY8_MEM_RD_LAT = 2;
    localparam int TINY8_MEM_WR_LAT = 1;

    function automatic int tiny8_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tiny8_mem_array.sv
// Byte storage for tiny8_mem: synchronous write, registered read, no reset.
// DEPTH must be a power of two and at least 2.
module tiny8_mem_array #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    localparam int IW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IW-1:0]         index,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write the addressed word when enabled; always register the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
        rdata <= mem[index];
    end

endmodule

// File: rtl/tiny8_mem.sv
// tiny8 memory responder: accepts one read/write request in IDLE, waits the
// programmed latency, then pulses mem_resp for one cycle.
// Optional feature macro: TINY8_MEM_BOUNDS_EN (flag addresses >= DEPTH;
// flagged writes are dropped, flagged reads return all-ones).
//
// state    | meaning
// MEM_IDLE | no request pending, sampling mem_read/mem_write
// MEM_WAIT | latency counter running
// MEM_RESP | mem_resp high for this single cycle
module tiny8_mem
    import tiny8_types::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 256,
    parameter int READ_LATENCY  = TINY8_MEM_RD_LAT,
    parameter int WRITE_LATENCY = TINY8_MEM_WR_LAT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_resp,
    output logic                  mem_err
);

    localparam int IW      = $clog2(DEPTH);
    localparam int MAX_LAT = tiny8_max(READ_LATENCY, WRITE_LATENCY);
    localparam int CW      = $clog2(MAX_LAT) + 1;
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

    tiny8_mem_state        state;
    logic [CW-1:0]         lat_cnt;
    logic                  op_write;
    logic [IW-1:0]         idx_q;
    logic                  oob_q;
    logic                  rd_live;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  resp_q;
    logic                  err_q;

    logic                  req;
    logic                  accept;
    logic                  oob;
    logic                  arr_we;
    logic [IW-1:0]         arr_index;
    logic [DATA_WIDTH-1:0] arr_rdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [CW-1:0]         load_val;

    assign req      = mem_read | mem_write;
    assign accept   = (state == MEM_IDLE) && req;
    assign load_val = mem_write ? WR_LOAD : RD_LOAD;

`ifdef TINY8_MEM_BOUNDS_EN
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
    assign oob = ({1'b0, mem_address} >= DEPTH_LIM);
`else
    // Upper address bits are ignored so accesses wrap modulo DEPTH.
    assign oob = 1'b0 & (|mem_address);
`endif

    assign arr_we = accept && mem_write && !oob;

    // While a request is in flight the array keeps re-reading the captured
    // index, so its registered output holds the word sampled at acceptance.
    assign arr_index = (state == MEM_IDLE) ? mem_address[IW-1:0] : idx_q;

    tiny8_mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk  (clk),
        .we   (arr_we),
        .index(arr_index),
        .wdata(mem_wdata),
        .rdata(arr_rdata)
    );

    assign rd_word   = oob_q ? '1 : arr_rdata;
    // In the read RESP cycle the fresh word comes straight from the array
    // register; afterwards it is parked in rdata_q until the next read.
    assign mem_rdata = rd_live ? rd_word : rdata_q;
    assign mem_resp  = resp_q;
    assign mem_err   = err_q;

    // Request FSM with latency down-counter and registered response flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MEM_IDLE;
            lat_cnt  <= '0;
            op_write <= 1'b0;
            idx_q    <= '0;
            oob_q    <= 1'b0;
            rd_live  <= 1'b0;
            rdata_q  <= '0;
            resp_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (req) begin
                        op_write <= mem_write;
                        idx_q    <= mem_address[IW-1:0];
                        oob_q    <= oob;
                        if (load_val == '0) begin
                            state   <= MEM_RESP;
                            lat_cnt <= '0;
                            resp_q  <= 1'b1;
                            err_q   <= oob;
                            rd_live <= !mem_write;
                        end else begin
                            state   <= MEM_WAIT;
                            lat_cnt <= load_val;
                        end
                    end
                end
                MEM_WAIT: begin
                    lat_cnt <= lat_cnt - CW'(1);
                    if (lat_cnt == CW'(1)) begin
                        state   <= MEM_RESP;
                        resp_q  <= 1'b1;
                        err_q   <= oob_q;
                        rd_live <= !op_write;
                    end
                end
                MEM_RESP: begin
                    state <= MEM_IDLE;
                    if (rd_live) begin
                        rdata_q <= rd_word;
                    end
                    rd_live <= 1'b0;
                end
                default: begin
                    state <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tiny8_mem.sv
// Self-checking bench for tiny8_mem (DEPTH=128, read latency 2, write latency 1).
module tb_tiny8_mem;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int DEP = 128;
    localparam int RL  = 2;
    localparam int WL  = 1;

`ifdef TINY8_MEM_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_address = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          mem_resp;
    logic          mem_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem [DEP];
    logic [7:0] last_rd = 8'h00;

    always #5 clk = ~clk;

    tiny8_mem #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .DEPTH        (DEP),
        .READ_LATENCY (RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp),
        .mem_err    (mem_err)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wd;
        int         exp_lat;
        logic [7:0] exp_rdata;
        logic       exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Present a request, hold it until mem_resp, then drop it and confirm the pulse ends.
    task automatic do_req(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [7:0] wd, output int lat,
                          output logic [7:0] rdata, output logic err);
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        mem_wdata   = wd;
        lat   = -1;
        rdata = 8'h00;
        err   = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (mem_resp) begin
                lat   = c;
                rdata = mem_rdata;
                err   = mem_err;
                break;
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        check("resp_one_cycle", {31'd0, mem_resp}, 32'd0);
    endtask

    // Run one request and compare against the reference memory model.
    task automatic run_op(input logic rd, input logic wr, input logic [7:0] addr, input logic [7:0] wd);
        bit         is_wr;
        bit         oob;
        int         idx;
        int         lat;
        logic [7:0] rdata;
        logic       err;
        logic [7:0] exp_rd;
        is_wr = wr;
        oob   = BOUNDS && (addr >= DEP);
        idx   = int'(addr) % DEP;
        do_req(rd, wr, addr, wd, lat, rdata, err);
        check("rnd_lat", lat, is_wr ? WL : RL);
        check("rnd_err", {31'd0, err}, {31'd0, oob});
        if (is_wr) begin
            check("rnd_wr_rdata_hold", {24'd0, rdata}, {24'd0, last_rd});
            if (!oob) model_mem[idx] = wd;
        end else begin
            exp_rd = oob ? 8'hFF : model_mem[idx];
            check("rnd_rdata", {24'd0, rdata}, {24'd0, exp_rd});
            last_rd = exp_rd;
        end
    endtask

    initial begin
        vec_t       vecs [10];
        int         lat;
        logic [7:0] rdata;
        logic       err;
        int         t1;
        int         t2;
        int         pulses;
        logic [7:0] held_rd;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp", {31'd0, mem_resp}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        check("rst_rdata", {24'd0, mem_rdata}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known contents everywhere.
        for (int i = 0; i < DEP; i++) begin
            model_mem[i] = 8'($urandom_range(0, 255));
            mem_read    = 1'b0;
            mem_write   = 1'b1;
            mem_address = 8'(i);
            mem_wdata   = model_mem[i];
            do_req(1'b0, 1'b1, 8'(i), model_mem[i], lat, rdata, err);
        end

        vecs[0] = '{1'b0, 1'b1, 8'h10, 8'h5A, WL, 8'h00, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, RL, 8'h5A, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'h20, 8'hC3, WL, 8'h5A, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h20, 8'h00, RL, 8'hC3, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h05, 8'h11, WL, 8'hC3, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h85, 8'h77, WL, 8'hC3, BOUNDS};
        vecs[6] = '{1'b1, 1'b0, 8'h05, 8'h00, RL, BOUNDS ? 8'h11 : 8'h77, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 8'h85, 8'h00, RL, BOUNDS ? 8'hFF : 8'h77, BOUNDS};
        vecs[8] = '{1'b0, 1'b1, 8'h7F, 8'h33, WL, BOUNDS ? 8'hFF : 8'h77, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 8'h7F, 8'h00, RL, 8'h33, 1'b0};

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, lat, rdata, err);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].exp_rdata});
            check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            if (vecs[i].wr && !vecs[i].exp_err) model_mem[int'(vecs[i].addr) % DEP] = vecs[i].wd;
            if (!vecs[i].wr) last_rd = vecs[i].exp_rdata;
        end

        // Read held through RESP: exactly one response, next one latency+1 later.
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        mem_address = 8'h10;
        t1 = -1;
        t2 = -1;
        pulses = 0;
        held_rd = 8'h00;
        for (int c = 1; c <= 20 && t2 < 0; c++) begin
            @(posedge clk);
            #1;
            if (mem_resp) begin
                pulses++;
                if (t1 < 0) t1 = c;
                else t2 = c;
                held_rd = mem_rdata;
            end
        end
        mem_read = 1'b0;
        check("held_first_lat", t1, RL);
        check("held_gap", t2 - t1, RL + 1);
        check("held_pulses", pulses, 2);
        check("held_rdata", {24'd0, held_rd}, {24'd0, model_mem[16]});
        last_rd = model_mem[16];
        @(posedge clk);
        #1;
        check("held_resp_drop", {31'd0, mem_resp}, 32'd0);

        // Reset while a read is waiting: no response, outputs cleared at once.
        mem_read    = 1'b1;
        mem_address = 8'h20;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("wait_rst_resp", {31'd0, mem_resp}, 32'd0);
        check("wait_rst_rdata", {24'd0, mem_rdata}, 32'd0);
        check("wait_rst_err", {31'd0, mem_err}, 32'd0);
        mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        last_rd = 8'h00;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (mem_resp) pulses++;
        end
        check("wait_rst_no_resp", pulses, 0);
        run_op(1'b1, 1'b0, 8'h10, 8'h00);
        check("post_rst_0x10", {24'd0, last_rd}, 32'h5A);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_op((kind == 0) || (kind == 2), (kind >= 1),
                   8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
